stream_demux_reg: RTL

//  Registered, parametrised 1-to-N_CH stream demultiplexer with valid/ready handshake.

---
 rtl/stream_demux_pkg.sv | 10 +
 rtl/stream_demux_if.sv | 28 ++
 rtl/stream_demux_rr_ptr.sv | 33 +++
 rtl/stream_demux_reg.sv | 98 +++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants for the registered stream demultiplexer.
package stream_demux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/stream_demux_if.sv
// Producer/consumer handshake bundle of the stream demultiplexer.
// The master modport is the environment side; the slave modport is the demux itself.
interface stream_demux_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) ();

  logic              mode;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [SEL_W-1:0]  s_sel;
  logic [N_CH-1:0]   m_valid;
  logic [N_CH-1:0]   m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output mode, s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  mode, s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/stream_demux_rr_ptr.sv
// Modulo-N_CH round-robin pointer; advances by one when en is high.
module stream_demux_rr_ptr #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [SEL_W-1:0] ptr
);

  localparam logic [SEL_W-1:0] Last = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == Last) ? '0 : ptr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/stream_demux_reg.sv
// Registered 1-to-N_CH stream demux: one-beat hold register, addressed or round-robin routing,
// saturating count of beats dropped for an out-of-range select.
module stream_demux_reg
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_demux_if.slave        bus,
  output logic [SEL_W-1:0]     rr_ptr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // One extra bit so N_CH = 2**SEL_W is representable in the range compare.
  localparam logic [SEL_W:0] NumCh = (SEL_W + 1)'(N_CH);

  logic                 hold_valid_q, hold_valid_d;
  logic [SEL_W-1:0]     hold_dest_q, hold_dest_d;
  logic [DATA_W-1:0]    hold_data_q, hold_data_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [N_CH-1:0]  m_valid_dec;
  logic [SEL_W-1:0] dest;
  logic             take;
  logic             in_ready;
  logic             accept;
  logic             sel_invalid;
  logic             rr_en;

  always_comb begin
    m_valid_dec = '0;
    for (int k = 0; k < N_CH; k++) begin
      m_valid_dec[k] = hold_valid_q && (hold_dest_q == SEL_W'(k));
    end
  end

  // Only the addressed channel's ready can complete the transfer.
  assign take        = |(m_valid_dec & bus.m_ready);
  assign in_ready    = ~hold_valid_q | take;
  assign accept      = bus.s_valid & in_ready;
  assign dest        = (bus.mode == MODE_RR) ? rr_ptr : bus.s_sel;
  assign sel_invalid = (bus.mode == MODE_ADDR) && ({1'b0, bus.s_sel} >= NumCh);
  assign rr_en       = accept && (bus.mode == MODE_RR);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_dest_d  = hold_dest_q;
    hold_data_d  = hold_data_q;
    err_cnt_d    = err_cnt_q;
    if (take) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      if (sel_invalid) begin
        if (err_cnt_q != ERR_CNT_MAX) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end else begin
        hold_valid_d = 1'b1;
        hold_dest_d  = dest;
        hold_data_d  = bus.s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_dest_q  <= '0;
      hold_data_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_dest_q  <= hold_dest_d;
      hold_data_q  <= hold_data_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  stream_demux_rr_ptr #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rr_en),
    .ptr (rr_ptr)
  );

  assign bus.s_ready = in_ready;
  assign bus.m_valid = m_valid_dec;
  assign bus.m_data  = hold_data_q;
  assign err_cnt     = err_cnt_q;

endmodule
